// File: rtl/pci_pkg.sv
// pci_pkg: shared PCI command opcodes, arbiter state encoding and defaults
package pci_pkg;
  localparam int N_MASTERS_DEF = 4;
  typedef enum logic [3:0] {
    SPECIAL_CYCLE = 4'b0001,
    IO_READ       = 4'b0010,
    IO_WRITE      = 4'b0011,
    MEM_READ      = 4'b0110,
    MEM_WRITE     = 4'b0111,
    CONFIG_READ   = 4'b1010,
    CONFIG_WRITE  = 4'b1011,
    READ_MULTIPLE = 4'b1100,
    DUAL_ADDRESS  = 4'b1101,
    READ_LINE     = 4'b1110
  } pci_cmd_e;
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, TURNAROUND} arb_state_e;
endpackage

// File: rtl/pci_rr_picker.sv
// pci_rr_picker: round-robin winner search starting at ptr, ascending with wrap
module pci_rr_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);
  logic [N-1:0] rot;
  assign rot = N'({req, req} >> ptr);
  assign any_req = |req;
  // lowest set bit of the rotated vector is the first requester at or after ptr
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) winner = W'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI bus arbiter with grant timeout and hidden arbitration
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int GNT_TIMEOUT = 16,
  localparam int W = $clog2(N_MASTERS),
  localparam int CW = $clog2(GNT_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] NREQ,
  input  logic                 NFRAME,
  input  logic                 NIRED,
  output logic [N_MASTERS-1:0] NGNT,
  output logic [W-1:0]         owner,
  output logic                 bus_busy,
  output logic                 timeout_evt
);
  arb_state_e state, state_n;
  logic [W-1:0] ptr, ptr_n, owner_n, winner;
  logic [CW-1:0] cnt, cnt_n;
  logic [N_MASTERS-1:0] ngnt_n, others;
  logic busy_n, tevt_n, any_req, bus_idle;
  pci_rr_picker #(.N(N_MASTERS)) u_pick (
    .req(~NREQ),
    .ptr(ptr),
    .winner(winner),
    .any_req(any_req)
  );
  assign bus_idle = NFRAME & NIRED;
  assign others = ~NREQ & ~(N_MASTERS'(1) << owner);
  // next-state and next-output logic; IDLE and TURNAROUND share the grant path
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    ngnt_n = NGNT;
    owner_n = owner;
    busy_n = bus_busy;
    tevt_n = 1'b0;
    case (state)
      GRANTED: begin
        if (!NFRAME) begin
          state_n = BUSY;
          busy_n = 1'b1;
        end else if (NREQ[owner]) begin
          ngnt_n = '1;
          state_n = IDLE;
        end else if (NIRED) begin
          cnt_n = (cnt == CW'(GNT_TIMEOUT)) ? cnt : cnt + 1'b1;
          if (cnt_n == CW'(GNT_TIMEOUT)) begin
            ngnt_n = '1;
            tevt_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      BUSY: begin
        if (bus_idle) begin
          state_n = TURNAROUND;
          busy_n = 1'b0;
          ngnt_n = '1;
        end else if (|others) ngnt_n = '1;
      end
      default: begin
        state_n = IDLE;
        ngnt_n = '1;
        busy_n = 1'b0;
        if (any_req) begin
          state_n = GRANTED;
          ngnt_n = ~(N_MASTERS'(1) << winner);
          owner_n = winner;
          ptr_n = (winner == W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
          cnt_n = '0;
        end
      end
    endcase
  end
  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      NGNT <= '1;
      owner <= '0;
      bus_busy <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      NGNT <= ngnt_n;
      owner <= owner_n;
      bus_busy <= busy_n;
      timeout_evt <= tevt_n;
    end
  end
endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed self-checking bench for pci_arbiter
module tb_pci_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] nreq, ngnt;
  logic nframe, nired;
  logic [1:0] owner;
  logic bus_busy, timeout_evt;
  int n_checks = 0;
  int n_errors = 0;
  bit started = 0;
  always #5 clk = ~clk;
  pci_arbiter #(.N_MASTERS(4), .GNT_TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .NREQ(nreq),
    .NFRAME(nframe),
    .NIRED(nired),
    .NGNT(ngnt),
    .owner(owner),
    .bus_busy(bus_busy),
    .timeout_evt(timeout_evt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // at most one grant low in any cycle
  always @(negedge clk)
    if (started) check("onehot", 32'($countones(~ngnt) <= 1), 1);
  initial begin
    reset = 1'b0;
    nreq = 4'b1111;
    nframe = 1'b1;
    nired = 1'b1;
    step();
    step();
    started = 1;
    check("rst_ngnt", ngnt, 4'b1111);
    check("rst_owner", owner, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_tevt", timeout_evt, 0);
    // single request, then a transaction
    reset = 1'b1;
    nreq = 4'b1110;
    step();
    check("g0_ngnt", ngnt, 4'b1110);
    check("g0_owner", owner, 0);
    nframe = 1'b0;
    step();
    check("g0_busy", bus_busy, 1);
    check("g0_hold", ngnt, 4'b1110);
    nframe = 1'b1;
    nreq = 4'b1111;
    step();
    check("g0_ta_busy", bus_busy, 0);
    check("g0_ta_ngnt", ngnt, 4'b1111);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    // all masters requesting: order 0,1,2,3,0
    nreq = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = ~(4'b0001 << (k % 4));
      step();
      check("rr_ngnt", ngnt, exp_g);
      check("rr_owner", owner, k % 4);
      nframe = 1'b0;
      step();
      check("rr_busy", bus_busy, 1);
      check("rr_held", ngnt, exp_g);
      step();
      check("rr_hidden", ngnt, 4'b1111);
      check("rr_busy2", bus_busy, 1);
      nframe = 1'b1;
      step();
      check("rr_ta", ngnt, 4'b1111);
      check("rr_ta_busy", bus_busy, 0);
    end
    nreq = 4'b1111;
    step();
    // timeout of master 2 on an idle bus
    nreq = 4'b1011;
    step();
    check("to_grant", ngnt, 4'b1011);
    check("to_owner", owner, 2);
    for (int k = 0; k < 15; k++) step();
    check("to_pre_ngnt", ngnt, 4'b1011);
    check("to_pre_evt", timeout_evt, 0);
    step();
    check("to_ngnt", ngnt, 4'b1111);
    check("to_evt", timeout_evt, 1);
    nreq = 4'b1111;
    step();
    check("to_evt_once", timeout_evt, 0);
    nreq = 4'b0000;
    step();
    check("to_ptr_ngnt", ngnt, 4'b0111);
    check("to_ptr_owner", owner, 3);
    nreq = 4'b1111;
    step();
    check("rel_ngnt", ngnt, 4'b1111);
    // hidden arbitration: master 1 busy, master 3 requests
    nreq = 4'b1101;
    step();
    check("ha_grant", ngnt, 4'b1101);
    nframe = 1'b0;
    step();
    check("ha_busy", bus_busy, 1);
    nreq = 4'b0111;
    step();
    check("ha_ngnt", ngnt, 4'b1111);
    check("ha_busy2", bus_busy, 1);
    nframe = 1'b1;
    step();
    check("ha_ta", ngnt, 4'b1111);
    check("ha_ta_busy", bus_busy, 0);
    step();
    check("ha_next", ngnt, 4'b0111);
    check("ha_owner", owner, 3);
    // reset in the middle of a transaction
    nframe = 1'b0;
    step();
    check("mr_busy", bus_busy, 1);
    reset = 1'b0;
    step();
    check("mr_ngnt", ngnt, 4'b1111);
    check("mr_busy0", bus_busy, 0);
    check("mr_owner", owner, 0);
    reset = 1'b1;
    nframe = 1'b1;
    nreq = 4'b1111;
    step();
    check("mr_nogrant", ngnt, 4'b1111);
    nreq = 4'b0000;
    step();
    check("mr_ptr", ngnt, 4'b1110);
    step();
    started = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 4: number of bus masters arbitrated; legal range 2..8.
REQ-002 Parameter GNT_TIMEOUT, default 16: idle-bus cycles a granted master may hold NGNT without starting a transaction.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 NREQ  input  N_MASTERS  per-master bus request, active-low.
REQ-006 NFRAME  input  1  PCI FRAME#, active-low, observed only.
REQ-007 NIRED  input  1  PCI IRDY#, active-low, observed only.
REQ-008 NGNT  output  N_MASTERS  per-master grant, active-low, registered.
REQ-009 owner  output  clog2(N_MASTERS)  index of current or most recent grant holder, registered.
REQ-010 bus_busy  output  1  high while a granted transaction is in progress, registered.
REQ-011 timeout_evt  output  1  one-cycle pulse when a grant is revoked for timeout.

Function
REQ-012 Bus idle SHALL be defined as NFRAME==1 and NIRED==1 when sampled at posedge clk.
REQ-013 At most one NGNT bit SHALL be low in any cycle.
REQ-014 States: IDLE, GRANTED, BUSY, TURNAROUND.
REQ-015 IDLE: if any NREQ bit is low, the winner's NGNT SHALL go low at that same edge and the FSM enters GRANTED; otherwise it stays in IDLE with all NGNT high.
REQ-016 Winner selection is round-robin: the search starts at ptr, ascending, wrapping modulo N_MASTERS; on each grant, ptr <= winner+1 mod N_MASTERS.
REQ-017 GRANTED: if NFRAME==0 is sampled, the FSM enters BUSY, bus_busy goes high, and NGNT is held.
REQ-018 GRANTED: if the owner's NREQ is high and NFRAME==1, NGNT goes all high and the FSM returns to IDLE.
REQ-019 GRANTED: a timeout counter increments each idle-bus cycle and saturates at GNT_TIMEOUT; on reaching GNT_TIMEOUT, NGNT goes all high, timeout_evt pulses for 1 cycle, and the FSM enters IDLE.
REQ-020 Counter width SHALL be clog2(GNT_TIMEOUT+1); the counter clears on every entry to GRANTED.
REQ-021 BUSY: if another master requests, the owner's NGNT SHALL be deasserted (hidden arbitration preparation) while bus_busy stays high.
REQ-022 BUSY exits to TURNAROUND on the first sampled bus-idle cycle; bus_busy clears on that edge.
REQ-023 TURNAROUND lasts exactly 1 cycle with all NGNT high, then re-evaluates requests exactly as in IDLE.
REQ-024 A request that deasserts during BUSY SHALL NOT abort the transaction; the arbiter only observes FRAME#/IRDY#.
REQ-025 Simultaneous requests resolve per REQ-016; requests from all N_MASTERS with ptr=0 are granted in the order 0,1,2,3,0.
REQ-026 owner updates on every grant and holds its value through IDLE.

Reset
REQ-027 With reset==0 at posedge clk: NGNT all 1, owner 0, bus_busy 0, timeout_evt 0, ptr 0, counter 0, state IDLE.
REQ-028 Reset mid-transaction SHALL take effect on the next edge regardless of NFRAME/NIRED; no grant SHALL be asserted in the first post-reset cycle.

Structure
REQ-029 Shared package pci_pkg SHALL hold the PCI command opcodes (SPECIAL_CYCLE..READ_LINE), the arbiter state encoding, and the N_MASTERS default.
REQ-030 Round-robin selection SHALL be a combinational sub-module pci_rr_picker (inputs: request vector, ptr; outputs: winner index, any_req).
REQ-031 The FSM, counter, and output registers SHALL reside in pci_arbiter.

Verification
REQ-032 Reset, then NREQ=4'b1110 -> NGNT=4'b1110 at next edge, owner=0; drive NFRAME=0 -> bus_busy=1.
REQ-033 NREQ=4'b0000 held, each master runs a 2-cycle transaction -> grant order 0,1,2,3,0, with one all-high TURNAROUND cycle between grants.
REQ-034 Grant master 2, keep NFRAME=NIRED=1 for 16 cycles -> NGNT=4'b1111 and timeout_evt=1 for exactly 1 cycle; ptr=3.
REQ-035 Master 1 in BUSY, NREQ[3] falls -> NGNT[1] goes high while bus_busy=1; after bus idle + TURNAROUND -> NGNT=4'b0111.
REQ-036 reset=0 asserted during BUSY -> next edge: NGNT=4'b1111, bus_busy=0, owner=0; no grant in the following cycle.
REQ-037 Assertion across all tests: never more than one NGNT bit low.
